// File: rtl/draw_pkg.sv
// Shared definitions for the GRAFIX draw command engine: opcodes, FSM states
// and operand sizing helpers.
package draw_pkg;

   localparam logic [7:0] OP_POINT_DEF = 8'd80;
   localparam logic [7:0] OP_LINE_DEF  = 8'd76;

   // Extra bits the Bresenham error term needs beyond the coordinate width.
   localparam int ERR_EXTRA = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OPERAND,
      ST_SETUP,
      ST_PLOT
   } state_e;

   // Number of operand bytes per coordinate, LSB byte first on the stream.
   function automatic int cb_of(input int coord_w);
      return (coord_w + 7) / 8;
   endfunction

endpackage

// File: rtl/line_stepper.sv
// Integer Bresenham core: latches a segment on load_i, advances one pixel per
// step_i and flags when the current position equals the end point.
module line_stepper
   import draw_pkg::*;
#(
   parameter int COORD_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [COORD_W-1:0] xs_i,
   input  logic [COORD_W-1:0] ys_i,
   input  logic [COORD_W-1:0] xe_i,
   input  logic [COORD_W-1:0] ye_i,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic               at_end_o
);

   localparam int ERR_W = COORD_W + ERR_EXTRA;
   localparam logic [COORD_W-1:0] ONE = 1;

   logic [COORD_W-1:0]      x_q, y_q, xe_q, ye_q, dx_q, dy_q;
   logic                    sx_neg_q, sy_neg_q;
   logic signed [ERR_W-1:0] err_q, err_d;
   logic [COORD_W-1:0]      dx_ld, dy_ld, x_d, y_d;
   logic signed [ERR_W:0]   e2;
   logic                    step_x, step_y;

   always_comb begin
      dx_ld  = (xe_i >= xs_i) ? xe_i - xs_i : xs_i - xe_i;
      dy_ld  = (ye_i >= ys_i) ? ye_i - ys_i : ys_i - ye_i;
      e2     = {err_q, 1'b0};
      step_x = e2 > -$signed({3'b000, dy_q});
      step_y = e2 < $signed({3'b000, dx_q});
      err_d  = err_q;
      x_d    = x_q;
      y_d    = y_q;
      // Both axis updates may fire together on a diagonal step.
      if (step_x) begin
         err_d = err_d - $signed({2'b00, dy_q});
         x_d   = sx_neg_q ? x_q - ONE : x_q + ONE;
      end
      if (step_y) begin
         err_d = err_d + $signed({2'b00, dx_q});
         y_d   = sy_neg_q ? y_q - ONE : y_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q      <= '0;
         y_q      <= '0;
         xe_q     <= '0;
         ye_q     <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
         err_q    <= '0;
      end else if (load_i) begin
         x_q      <= xs_i;
         y_q      <= ys_i;
         xe_q     <= xe_i;
         ye_q     <= ye_i;
         dx_q     <= dx_ld;
         dy_q     <= dy_ld;
         sx_neg_q <= xe_i < xs_i;
         sy_neg_q <= ye_i < ys_i;
         err_q    <= $signed({2'b00, dx_ld}) - $signed({2'b00, dy_ld});
      end else if (step_i) begin
         x_q   <= x_d;
         y_q   <= y_d;
         err_q <= err_d;
      end
   end

   assign x_o      = x_q;
   assign y_o      = y_q;
   assign at_end_o = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/draw_cmd_engine.sv
// GRAFIX command engine: parses point/line commands from a byte stream and
// rasterises them into a backpressured pixel stream.
module draw_cmd_engine
   import draw_pkg::*;
#(
   parameter int         COORD_W  = 8,
   parameter int         COLOR_W  = 8,
   parameter logic [7:0] OP_POINT = OP_POINT_DEF,
   parameter logic [7:0] OP_LINE  = OP_LINE_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [7:0]         cmd_data,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [COLOR_W-1:0] pix_color,
   output logic               busy,
   output logic               cmd_done,
   output logic               err_opcode
);

   localparam int CB = cb_of(COORD_W);
   localparam int CW = CB * 8;

   state_e             state_q;
   logic               cmd_ready_q, pix_valid_q, busy_q, err_opcode_q;
   logic               is_line_q, byt_q;
   logic [2:0]         fld_q;
   logic [CW-1:0]      crd_q [4];
   logic [COLOR_W-1:0] color_q;

   logic [2:0]         col_fld;
   logic               cmd_fire, pix_fire, byte_last, load, step, at_end;
   logic [COORD_W-1:0] xe_sel, ye_sel;

   // Both streams transfer on valid && ready at the rising edge; a producer
   // holds its data stable while valid is high and ready is low.
   assign cmd_fire  = cmd_valid && cmd_ready_q;
   assign pix_fire  = pix_valid_q && pix_ready;
   assign col_fld   = is_line_q ? 3'd4 : 3'd2;
   assign byte_last = (CB == 1) || byt_q;
   assign load      = (state_q == ST_SETUP);
   assign step      = pix_fire && !at_end;
   assign xe_sel    = is_line_q ? crd_q[2][COORD_W-1:0] : crd_q[0][COORD_W-1:0];
   assign ye_sel    = is_line_q ? crd_q[3][COORD_W-1:0] : crd_q[1][COORD_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cmd_ready_q  <= 1'b1;
         pix_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         err_opcode_q <= 1'b0;
         is_line_q    <= 1'b0;
         byt_q        <= 1'b0;
         fld_q        <= '0;
         color_q      <= '0;
         for (int i = 0; i < 4; i++) crd_q[i] <= '0;
      end else begin
         err_opcode_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_fire) begin
                  fld_q <= '0;
                  byt_q <= 1'b0;
                  if (cmd_data == OP_POINT || cmd_data == OP_LINE) begin
                     is_line_q <= (cmd_data == OP_LINE);
                     state_q   <= ST_OPERAND;
                     busy_q    <= 1'b1;
                  end else begin
                     err_opcode_q <= 1'b1;
                  end
               end
            end
            ST_OPERAND: begin
               if (cmd_fire) begin
                  if (fld_q == col_fld) begin
                     color_q     <= cmd_data[COLOR_W-1:0];
                     state_q     <= ST_SETUP;
                     cmd_ready_q <= 1'b0;
                  end else begin
                     if (byt_q) crd_q[fld_q[1:0]][CW-1 -: 8] <= cmd_data;
                     else       crd_q[fld_q[1:0]][7:0]       <= cmd_data;
                     if (byte_last) begin
                        byt_q <= 1'b0;
                        fld_q <= fld_q + 3'd1;
                     end else begin
                        byt_q <= 1'b1;
                     end
                  end
               end
            end
            ST_SETUP: begin
               state_q     <= ST_PLOT;
               pix_valid_q <= 1'b1;
            end
            ST_PLOT: begin
               if (pix_fire && at_end) begin
                  state_q     <= ST_IDLE;
                  pix_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   line_stepper #(.COORD_W(COORD_W)) u_stepper (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load),
      .step_i   (step),
      .xs_i     (crd_q[0][COORD_W-1:0]),
      .ys_i     (crd_q[1][COORD_W-1:0]),
      .xe_i     (xe_sel),
      .ye_i     (ye_sel),
      .x_o      (pix_x),
      .y_o      (pix_y),
      .at_end_o (at_end)
   );

   assign cmd_ready  = cmd_ready_q;
   assign pix_valid  = pix_valid_q;
   assign pix_color  = color_q;
   assign busy       = busy_q;
   assign err_opcode = err_opcode_q;
   assign cmd_done   = pix_fire && at_end;

endmodule

// File: tb/tb_draw_cmd_engine.sv
// Randomised bench for draw_cmd_engine (12-bit coordinates, 2 bytes each)
// with a Bresenham pixel-list model and a per-cycle scoreboard.
module tb_draw_cmd_engine;
  localparam int CW = 12;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic pix_ready = 1'b1;
  logic cmd_ready, pix_valid, busy, cmd_done, err_opcode;
  logic [CW-1:0] pix_x, pix_y;
  logic [KW-1:0] pix_color;

  draw_cmd_engine #(.COORD_W(CW), .COLOR_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .busy(busy),
    .cmd_done(cmd_done), .err_opcode(err_opcode)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int rdy_pct = 100;
  int gap_max = 0;
  int err_sent = 0;
  int err_ack = 0;
  // expected pixel: {last, colour[7:0], x[11:0], y[11:0]}
  logic [32:0] exp_q[$];
  logic [32:0] mdl_q[$];
  int xm_exp[5][2] = '{'{0,0}, '{1,0}, '{2,1}, '{3,1}, '{4,2}};
  int st_exp[6][2] = '{'{2,5}, '{2,4}, '{2,3}, '{1,2}, '{1,1}, '{1,0}};

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pixel list from the endpoint rules, in plain integers.
  function automatic int model_line(input int xs, input int ys, input int xe, input int ye, input int c);
    int dx, dy, sx, sy, err, e2, x, y, n;
    logic [7:0] cb;
    logic [11:0] xb, yb;
    mdl_q.delete();
    dx = (xe > xs) ? xe - xs : xs - xe;
    dy = (ye > ys) ? ye - ys : ys - ye;
    sx = (xe >= xs) ? 1 : -1;
    sy = (ye >= ys) ? 1 : -1;
    err = dx - dy;
    x = xs;
    y = ys;
    n = 0;
    cb = c[7:0];
    while (n < 10000) begin
      xb = x[11:0];
      yb = y[11:0];
      mdl_q.push_back({(x == xe && y == ye), cb, xb, yb});
      n++;
      if (x == xe && y == ye) break;
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx) begin err += dx; y += sy; end
    end
    return n;
  endfunction

  // pix_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pix_ready = (rdy_pct >= 100) || ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int budget;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data = b;
    budget = 0;
    while (!cmd_ready && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) chk_eq("cmd_ready_timeout", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_coord(input logic [11:0] v);
    send_byte(v[7:0]);
    send_byte({4'h0, v[11:8]});
  endtask

  task automatic push_model();
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
  endtask

  task automatic send_line(input logic [11:0] xs, input logic [11:0] ys,
                           input logic [11:0] xe, input logic [11:0] ye, input logic [7:0] c);
    int n, dx, dy;
    n = model_line(int'(xs), int'(ys), int'(xe), int'(ye), int'(c));
    dx = (xe > xs) ? int'(xe - xs) : int'(xs - xe);
    dy = (ye > ys) ? int'(ye - ys) : int'(ys - ye);
    chk_eq("model_count", n, ((dx > dy) ? dx : dy) + 1);
    push_model();
    send_byte(8'd76);
    send_coord(xs); send_coord(ys); send_coord(xe); send_coord(ye);
    send_byte(c);
  endtask

  task automatic send_point(input logic [11:0] x, input logic [11:0] y, input logic [7:0] c);
    void'(model_line(int'(x), int'(y), int'(x), int'(y), int'(c)));
    push_model();
    send_byte(8'd80);
    send_coord(x); send_coord(y);
    send_byte(c);
  endtask

  task automatic send_bad(input logic [7:0] b);
    send_byte(b);
    err_sent++;
  endtask

  task automatic check_burst(input int n, input string name);
    @(negedge clk);
    chk_eq({name, "_setup_gap"}, pix_valid, 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_eq({name, "_valid"}, pix_valid, 1);
      chk_eq({name, "_done"}, cmd_done, (i == n - 1));
    end
    @(negedge clk);
    chk_eq({name, "_end_valid"}, pix_valid, 0);
    chk_eq({name, "_end_busy"}, busy, 0);
    chk_eq({name, "_end_ready"}, cmd_ready, 1);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((exp_q.size() != 0 || pix_valid) && k < 30000);
    chk_eq({name, "_drained"}, exp_q.size(), 0);
    chk_eq({name, "_busy"}, busy, 0);
    chk_eq({name, "_ready"}, cmd_ready, 1);
  endtask

  // scoreboard: compare on every cycle, away from the active edge
  logic [31:0] prev_pix;
  bit prev_stall = 0;
  logic [32:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 0;
      err_ack = err_sent;
    end else begin
      chk_eq("err_opcode", err_opcode, (err_sent > err_ack));
      if (err_sent > err_ack) err_ack++;
      if (pix_valid) begin
        chk_eq("busy_plot", busy, 1);
        chk_eq("cmd_ready_plot", cmd_ready, 0);
        if (prev_stall) chk_eq("stall_hold", {pix_color, pix_x, pix_y}, prev_pix);
        chk_eq("pixel_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk_eq("pix_x", pix_x, e[23:12]);
          chk_eq("pix_y", pix_y, e[11:0]);
          chk_eq("pix_color", pix_color, e[31:24]);
          chk_eq("cmd_done", cmd_done, (pix_ready && e[32]));
          if (pix_ready) void'(exp_q.pop_front());
        end
        prev_stall = !pix_ready;
        prev_pix = {pix_color, pix_x, pix_y};
      end else begin
        chk_eq("cmd_done_idle", cmd_done, 0);
        prev_stall = 0;
      end
    end
  end

  int n, r, ctr;
  logic [7:0] b;

  initial begin
    repeat (3) @(negedge clk);
    chk_eq("rst_cmd_ready", cmd_ready, 1);
    chk_eq("rst_pix_valid", pix_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_cmd_done", cmd_done, 0);
    chk_eq("rst_err_opcode", err_opcode, 0);
    chk_eq("rst_pix", {pix_x, pix_y, pix_color}, 0);
    rst_n = 1'b1;

    // pin the model against hand-computed pixel lists
    n = model_line(0, 0, 4, 2, 'h11);
    chk_eq("model_xm_count", n, 5);
    for (int i = 0; i < 5 && i < mdl_q.size(); i++) begin
      chk_eq("model_xm_x", mdl_q[i][23:12], xm_exp[i][0]);
      chk_eq("model_xm_y", mdl_q[i][11:0], xm_exp[i][1]);
    end
    n = model_line(2, 5, 1, 0, 'h22);
    chk_eq("model_st_count", n, 6);
    for (int i = 0; i < 6 && i < mdl_q.size(); i++) begin
      chk_eq("model_st_x", mdl_q[i][23:12], st_exp[i][0]);
      chk_eq("model_st_y", mdl_q[i][11:0], st_exp[i][1]);
    end
    n = model_line(0, 0, 4095, 0, 1);
    chk_eq("model_full_count", n, 4096);

    // directed cases at full throughput
    send_point(12'd3, 12'd4, 8'hAA);
    check_burst(1, "point");
    send_line(12'd0, 12'd0, 12'd4, 12'd2, 8'h11);
    check_burst(5, "xmajor");
    send_line(12'd2, 12'd5, 12'd1, 12'd0, 8'h22);
    check_burst(6, "steep");

    rdy_pct = 50;
    send_line(12'd0, 12'd0, 12'd4, 12'd2, 8'h11);
    wait_drain("backpressure");

    rdy_pct = 100;
    send_bad(8'h41);
    @(negedge clk);
    chk_eq("bad_busy", busy, 0);
    chk_eq("bad_ready", cmd_ready, 1);
    send_line(12'd7, 12'd7, 12'd7, 12'd7, 8'h01);
    check_burst(1, "degenerate");

    rdy_pct = 70;
    send_line(12'd0, 12'd0, 12'd4095, 12'd0, 8'h05);
    send_line(12'd4095, 12'd4095, 12'd0, 12'd3, 8'h06);
    wait_drain("full_range");

    // randomised traffic, back to back with gaps and stalls
    gap_max = 2;
    rdy_pct = 60;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'd80 || b == 8'd76);
        send_bad(b);
      end else if (r < 3) begin
        send_point(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)));
      end else begin
        ctr = $urandom_range(0, 4000);
        send_line(12'(ctr + $urandom_range(0, 40)), 12'(ctr + $urandom_range(0, 40)),
                  12'(ctr + $urandom_range(0, 40)), 12'(ctr + $urandom_range(0, 40)),
                  8'($urandom_range(0, 255)));
      end
    end
    wait_drain("random");
    gap_max = 0;

    // reset in the middle of a line
    rdy_pct = 100;
    send_line(12'd5, 12'd0, 12'd10, 12'd0, 8'h33);
    @(negedge clk);
    chk_eq("rstline_setup", pix_valid, 0);
    @(negedge clk);
    chk_eq("rstline_p1_x", pix_x, 5);
    @(negedge clk);
    chk_eq("rstline_p2_x", pix_x, 6);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("midrst_pix_valid", pix_valid, 0);
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_cmd_ready", cmd_ready, 1);
    chk_eq("midrst_cmd_done", cmd_done, 0);
    chk_eq("midrst_pix", {pix_x, pix_y, pix_color}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("postrst_pix_valid", pix_valid, 0);
    chk_eq("postrst_busy", busy, 0);
    send_point(12'd3, 12'd4, 8'hAA);
    check_burst(1, "postrst_point");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_cmd_engine.md
Name: draw_cmd_engine

Overview:
Parametrised second-generation command control unit for the GRAFIX pipeline. It accepts a byte stream of drawing commands (opcode followed by operand bytes) over a valid/ready handshake. It rasterises points and lines in all eight octants using an integer Bresenham core, and emits one pixel (x, y, colour) per cycle on a backpressured pixel stream towards the frame-buffer writer. It generalises the first-generation CCU with configurable coordinate width, multi-byte operands, all-octant lines, flow control and error reporting.

Parameters:
COORD_W, 8, coordinate width in bits (8..16); each coordinate occupies CB = ceil(COORD_W/8) operand bytes, LSB byte first
COLOR_W, 8, colour width in bits (1..8); taken from the low bits of one operand byte
OP_POINT, 8'd80, opcode 'P': operands x, y, colour
OP_LINE, 8'd76, opcode 'L': operands xs, ys, xe, ye, colour

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command byte valid
cmd_ready  out  1  engine can accept a command byte
cmd_data  in  8  opcode or operand byte
pix_valid  out  1  pixel output valid
pix_ready  in  1  downstream accepts pixel
pix_x  out  COORD_W  pixel x
pix_y  out  COORD_W  pixel y
pix_color  out  COLOR_W  pixel colour
busy  out  1  high whenever state != IDLE
cmd_done  out  1  one-cycle pulse on the handshake of the final pixel of a command
err_opcode  out  1  one-cycle pulse when an unknown opcode is consumed

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; pix_valid, busy, cmd_done, err_opcode = 0; pix_x/pix_y/pix_color = 0; operand registers cleared. Reset mid-command discards partial operands and in-flight pixels; no cmd_done is issued.
- Byte transfer occurs on cmd_valid && cmd_ready. Pixel transfer occurs on pix_valid && pix_ready.
- FSM states:
  - IDLE: cmd_ready=1. OP_POINT -> OPERAND (expects 2*CB+1 bytes). OP_LINE -> OPERAND (expects 4*CB+1 bytes). Any other byte is consumed, pulses err_opcode the next cycle, and the FSM stays in IDLE.
  - OPERAND: cmd_ready=1. A byte counter fills the operand registers in order. The last byte moves to SETUP. For points, xe=xs and ye=ys.
  - SETUP (1 cycle): cmd_ready=0. Computes dx=|xe-xs|, dy=|ye-ys|, sx=+/-1, sy=+/-1 (sign is +1 when equal), err=dx-dy. err is a signed value of COORD_W+2 bits. Loads x=xs, y=ys. Goes to PLOT.
  - PLOT: pix_valid=1 with registered outputs x, y, colour. On each pixel handshake:
    - If x==xe and y==ye: pulse cmd_done and go to IDLE (cmd_ready is high the following cycle).
    - Otherwise compute e2=2*err (COORD_W+3 bits signed).
    - If e2 > -dy: err-=dy and x+=sx. If e2 < dx: err+=dx and y+=sy. Both updates apply in the same cycle when both conditions hold.
- Latency: last operand accepted in cycle T -> pix_valid high in cycle T+2.
- Throughput: 1 pixel/cycle while pix_ready=1. A command emits max(dx,dy)+1 pixels.
- Backpressure: while pix_valid && !pix_ready, pix_x/pix_y/pix_color are held stable and no internal state advances.
- x and y never wrap, since they stay within [min,max] of the endpoints. Full range dx=2^COORD_W-1 is supported.
- Degenerate line (xs==xe, ys==ye) emits exactly one pixel.
- Commands never overlap: cmd_ready=0 from SETUP until the cycle after the final pixel handshake.

Decomposition:
- Shared package draw_pkg: opcode constants, FSM state enum, CB computation function, and the signed error width localparam.
- One sub-module, line_stepper: holds x, y, err, dx, dy, sx, sy. Load, step and at_end signals. The top holds the FSM, operand capture and handshakes.

Test Plan:
- Point: 80,3,4,0xAA -> single pixel (3,4,0xAA) in cycle T+2; cmd_done with its handshake; busy low afterwards.
- X-major line: 76,0,0,4,2,0x11 -> (0,0),(1,0),(2,1),(3,1),(4,2), all colour 0x11, on consecutive cycles with pix_ready=1.
- Steep negative octant: 76,2,5,1,0,0x22 -> (2,5),(2,4),(2,3),(1,2),(1,1),(1,0); cmd_done on the 6th pixel.
- Backpressure: repeat the x-major case with pix_ready random 50% -> identical sequence, outputs stable while stalled, no drops or duplicates, cmd_ready low throughout.
- Error and degenerate cases: byte 0x41 -> err_opcode pulse, still IDLE, cmd_ready=1. Then 76,7,7,7,7,0x01 -> exactly one pixel (7,7).
- COORD_W=12 and reset: 76,0x05,0x00,0x00,0x00,0x0A,0x00,0x00,0x00,0x33 -> pixels (5,0)..(10,0); assert rst_n low after the 2nd pixel -> pix_valid=0, IDLE, no cmd_done. A following point command works normally.
